// File: rtl/vga_pkg.sv
// Shared VGA definitions: colour modes, default 640x480@60 timing and the colour-bar table.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_GRAD    = 2'd3
    } mode_t;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;
    localparam int unsigned CLK_DIV_DEF  = 2;
    localparam int unsigned COLOR_W_DEF  = 8;
    localparam int unsigned CNT_W_DEF    = 11;

    localparam int unsigned NUM_BARS = 8;

    // {R,G,B} on-flags; index 0 (white) is the leftmost bar, index 7 (black) the rightmost
    localparam logic [NUM_BARS-1:0][2:0] BAR_TABLE = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate divider: one-clk pixel enable per CLK_DIV system clocks and a 50% duty DAC clock.
module vga_pix_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic pix_en_c,
    output logic clock_vga
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt_c;

    assign pix_en_c  = (div == DIV_LAST);
    assign div_nxt_c = pix_en_c ? '0 : div + DIV_W'(1);

    // clock_vga is registered from the next divider value so it tracks div >= CLK_DIV/2
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div       <= '0;
            clock_vga <= 1'b0;
        end else begin
            div       <= div_nxt_c;
            clock_vga <= (div_nxt_c >= DIV_HALF);
        end
    end

endmodule

// File: rtl/vga_timing_pattern_gen.sv
// Parametrised VGA timing generator with a registered four-mode test-pattern colour source.
module vga_timing_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
    parameter int unsigned COLOR_W  = COLOR_W_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] solid_color,
    output logic                 vga_hs,
    output logic                 vga_vs,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 vga_blank_n,
    output logic                 clockVGA,
    output logic [CNT_W-1:0]     pix_x,
    output logic [CNT_W-1:0]     pix_y,
    output logic                 frame_start
);

    localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END = V_ACTIVE + V_FP + V_SYNC;
    localparam int unsigned BAR_W      = H_ACTIVE / NUM_BARS;
    localparam int unsigned RGB_W      = 3 * COLOR_W;

    logic               pix_en_c;
    logic [CNT_W-1:0]   h;
    logic [CNT_W-1:0]   v;
    logic               h_last_c;
    logic               v_last_c;
    logic               origin_c;
    logic               active_c;
    logic               hs_act_c;
    logic               vs_act_c;
    mode_t              mode_act;
    mode_t              mode_eff_c;
    logic [2:0]         bar_idx_c;
    logic [2:0]         bar_on_c;
    logic [RGB_W-1:0]   rgb_c;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .clk       (clk),
        .reset     (reset),
        .pix_en_c  (pix_en_c),
        .clock_vga (clockVGA)
    );

    assign h_last_c = (h == CNT_W'(H_TOTAL - 1));
    assign v_last_c = (v == CNT_W'(V_TOTAL - 1));
    assign origin_c = (h == '0) && (v == '0);

    // Raster counters, stepped once per pixel period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (pix_en_c) begin
            if (h_last_c) begin
                h <= '0;
                v <= v_last_c ? '0 : v + CNT_W'(1);
            end else begin
                h <= h + CNT_W'(1);
            end
        end
    end

    assign active_c = (h < CNT_W'(H_ACTIVE)) && (v < CNT_W'(V_ACTIVE));
    assign hs_act_c = (h >= CNT_W'(H_SYNC_BEG)) && (h < CNT_W'(H_SYNC_END));
    assign vs_act_c = (v >= CNT_W'(V_SYNC_BEG)) && (v < CNT_W'(V_SYNC_END));

    // The origin pixel already uses the incoming mode so the whole new frame is consistent
    assign mode_eff_c = origin_c ? mode_t'(mode) : mode_act;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_act <= MODE_SOLID;
        end else if (pix_en_c && origin_c) begin
            mode_act <= mode_t'(mode);
        end
    end

    assign bar_idx_c = 3'(h / CNT_W'(BAR_W));
    assign bar_on_c  = BAR_TABLE[bar_idx_c];

    always_comb begin
        rgb_c = '0;
        if (active_c) begin
            case (mode_eff_c)
                MODE_SOLID:   rgb_c = solid_color;
                MODE_BARS:    rgb_c = {{COLOR_W{bar_on_c[2]}}, {COLOR_W{bar_on_c[1]}},
                                       {COLOR_W{bar_on_c[0]}}};
                MODE_CHECKER: rgb_c = (h[5] ^ v[5]) ? solid_color : '0;
                MODE_GRAD:    rgb_c = {COLOR_W'(h), COLOR_W'(v), solid_color[COLOR_W-1:0]};
            endcase
        end
    end

    // Output stage: everything loads on the same pixel enable, one pixel behind the counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_hs      <= ~HS_POL;
            vga_vs      <= ~VS_POL;
            vga_blank_n <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en_c && origin_c;
            if (pix_en_c) begin
                vga_hs      <= hs_act_c ? HS_POL : ~HS_POL;
                vga_vs      <= vs_act_c ? VS_POL : ~VS_POL;
                vga_blank_n <= active_c;
                red         <= rgb_c[RGB_W-1 -: COLOR_W];
                green       <= rgb_c[2*COLOR_W-1 -: COLOR_W];
                blue        <= rgb_c[COLOR_W-1:0];
                pix_x       <= h;
                pix_y       <= v;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Bench for vga_timing_pattern_gen: three configurations checked every clock against a raster-arithmetic model.
module tb_vga_timing_pattern_gen;

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        int dv; bit hp; bit vp;
    } tim_t;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        bn;
        logic        fs;
        logic        ck;
        logic [23:0] rgb;
        logic [10:0] x;
        logic [10:0] y;
        logic [1:0]  fm;
    } obs_t;

    localparam tim_t TA = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, dv:2, hp:1'b0, vp:1'b0};
    localparam tim_t TB = '{ha:8, hf:1, hs:2, hb:1, va:4, vf:1, vs:1, vb:1, dv:4, hp:1'b1, vp:1'b1};
    localparam tim_t TC = '{ha:64, hf:4, hs:8, hb:4, va:70, vf:2, vs:3, vb:2, dv:2, hp:1'b0, vp:1'b0};

    logic clk = 1'b0;
    logic rst;
    bit   chk_on = 1'b0;
    bit   rand_c = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [1:0]  mode_a, mode_b, mode_c;
    logic [23:0] sc_a, sc_b, sc_c;
    logic        hs_a, vs_a, bn_a, ck_a, fs_a;
    logic        hs_b, vs_b, bn_b, ck_b, fs_b;
    logic        hs_c, vs_c, bn_c, ck_c, fs_c;
    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
    logic [10:0] x_a, y_a, x_b, y_b, x_c, y_c;

    always #5 clk = ~clk;

    vga_timing_pattern_gen u_dut_a (
        .clk(clk), .reset(rst), .mode(mode_a), .solid_color(sc_a),
        .vga_hs(hs_a), .vga_vs(vs_a), .red(r_a), .green(g_a), .blue(b_a),
        .vga_blank_n(bn_a), .clockVGA(ck_a), .pix_x(x_a), .pix_y(y_a), .frame_start(fs_a)
    );

    vga_timing_pattern_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(4)
    ) u_dut_b (
        .clk(clk), .reset(rst), .mode(mode_b), .solid_color(sc_b),
        .vga_hs(hs_b), .vga_vs(vs_b), .red(r_b), .green(g_b), .blue(b_b),
        .vga_blank_n(bn_b), .clockVGA(ck_b), .pix_x(x_b), .pix_y(y_b), .frame_start(fs_b)
    );

    vga_timing_pattern_gen #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(70), .V_FP(2), .V_SYNC(3), .V_BP(2),
        .CLK_DIV(2)
    ) u_dut_c (
        .clk(clk), .reset(rst), .mode(mode_c), .solid_color(sc_c),
        .vga_hs(hs_c), .vga_vs(vs_c), .red(r_c), .green(g_c), .blue(b_c),
        .vga_blank_n(bn_c), .clockVGA(ck_c), .pix_x(x_c), .pix_y(y_c), .frame_start(fs_c)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] bar_colour(int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] colour(logic [1:0] md, int x, int y, int ha, logic [23:0] sc);
        case (md)
            2'd0: return sc;
            2'd1: return bar_colour(x / (ha / 8));
            2'd2: return (((x / 32) + (y / 32)) % 2 == 1) ? sc : 24'h0;
            default: return {8'(x % 256), 8'(y % 256), sc[7:0]};
        endcase
    endfunction

    function automatic obs_t reset_obs(tim_t t);
        obs_t e;
        e     = '0;
        e.hs  = ~t.hp;
        e.vs  = ~t.vp;
        return e;
    endfunction

    // Expected outputs after the k-th clock edge since reset release, from raster arithmetic
    function automatic obs_t step(tim_t t, int k, logic [1:0] md, logic [23:0] sc, obs_t prev);
        obs_t e;
        int   p, x, y, htot, vtot;
        bit   act;
        e    = prev;
        e.ck = ((k % t.dv) >= (t.dv / 2));
        e.fs = 1'b0;
        if (k % t.dv == 0) begin
            htot = t.ha + t.hf + t.hs + t.hb;
            vtot = t.va + t.vf + t.vs + t.vb;
            p    = k / t.dv - 1;
            x    = p % htot;
            y    = (p / htot) % vtot;
            act  = (x < t.ha) && (y < t.va);
            if (x == 0 && y == 0) begin
                e.fm = md;
                e.fs = 1'b1;
            end
            e.x   = 11'(x);
            e.y   = 11'(y);
            e.bn  = act;
            e.hs  = (x >= t.ha + t.hf && x < t.ha + t.hf + t.hs) ? t.hp : ~t.hp;
            e.vs  = (y >= t.va + t.vf && y < t.va + t.vf + t.vs) ? t.vp : ~t.vp;
            e.rgb = act ? colour(e.fm, x, y, t.ha, sc) : 24'h0;
        end
        return e;
    endfunction

    int   k_a, k_b, k_c;
    obs_t e_a, e_b, e_c;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k_a = 0; k_b = 0; k_c = 0;
            e_a = reset_obs(TA); e_b = reset_obs(TB); e_c = reset_obs(TC);
        end else begin
            k_a++; k_b++; k_c++;
            e_a = step(TA, k_a, mode_a, sc_a, e_a);
            e_b = step(TB, k_b, mode_b, sc_b, e_b);
            e_c = step(TC, k_c, mode_c, sc_c, e_c);
        end
    end

    function automatic obs_t obs(logic hs, logic vs, logic bn, logic fs, logic ck,
                                 logic [7:0] r, logic [7:0] g, logic [7:0] b,
                                 logic [10:0] x, logic [10:0] y);
        obs_t o;
        o.hs = hs; o.vs = vs; o.bn = bn; o.fs = fs; o.ck = ck;
        o.rgb = {r, g, b}; o.x = x; o.y = y; o.fm = 2'd0;
        return o;
    endfunction

    task automatic cmp(input string n, input obs_t e, input obs_t o);
        check({n, ".hs"},  64'(o.hs),  64'(e.hs));
        check({n, ".vs"},  64'(o.vs),  64'(e.vs));
        check({n, ".bn"},  64'(o.bn),  64'(e.bn));
        check({n, ".fs"},  64'(o.fs),  64'(e.fs));
        check({n, ".ck"},  64'(o.ck),  64'(e.ck));
        check({n, ".rgb"}, 64'(o.rgb), 64'(e.rgb));
        check({n, ".x"},   64'(o.x),   64'(e.x));
        check({n, ".y"},   64'(o.y),   64'(e.y));
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("a", e_a, obs(hs_a, vs_a, bn_a, fs_a, ck_a, r_a, g_a, b_a, x_a, y_a));
            cmp("b", e_b, obs(hs_b, vs_b, bn_b, fs_b, ck_b, r_b, g_b, b_b, x_b, y_b));
            cmp("c", e_c, obs(hs_c, vs_c, bn_c, fs_c, ck_c, r_c, g_c, b_c, x_c, y_c));
        end
    end

    // Random colour/mode churn; mode changes are only seen by the DUT at frame origins
    initial begin
        forever begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) sc_a = 24'($urandom);
            if ($urandom_range(0, 7) == 0) sc_b = 24'($urandom);
            if ($urandom_range(0, 99) == 0) mode_b = 2'($urandom_range(0, 3));
            if (rand_c && $urandom_range(0, 7) == 0) sc_c = 24'($urandom);
        end
    end

    function automatic bit pix_is(int u, int x, int y);
        case (u)
            0:       return (x_a == 11'(x)) && (y < 0 || y_a == 11'(y));
            1:       return (x_b == 11'(x)) && (y < 0 || y_b == 11'(y));
            default: return (x_c == 11'(x)) && (y < 0 || y_c == 11'(y));
        endcase
    endfunction

    task automatic wait_pix(input int u, input int x, input int y, input int lim);
        int n = 0;
        while (!pix_is(u, x, y) && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (n >= lim) check("wait_pix_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_fs_c(input int lim);
        int n = 0;
        while (!fs_c && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (n >= lim) check("wait_fs_timeout", 64'(0), 64'(1));
    endtask

    task automatic count_while(input logic lvl, input int u, output int n);
        n = 0;
        while ((u == 0 ? hs_a : hs_b) == lvl && n < 5000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n, lo, hi;
        rst = 1'b0; mode_a = 2'd1; mode_b = 2'd0; mode_c = 2'd0;
        sc_a = 24'($urandom); sc_b = 24'($urandom);
        sc_c = 24'($urandom) | 24'h800000;
        #1 rst = 1'b1;
        chk_on = 1'b1;
        repeat (4) @(negedge clk);
        check("rst.a.hs", 64'(hs_a), 64'(1));
        check("rst.a.vs", 64'(vs_a), 64'(1));
        check("rst.b.hs", 64'(hs_b), 64'(0));
        check("rst.b.vs", 64'(vs_b), 64'(0));
        check("rst.a.bn", 64'(bn_a), 64'(0));
        check("rst.a.ck", 64'(ck_a), 64'(0));
        rst = 1'b0;

        // default line timing, measured from the start of line 1
        wait_pix(0, 0, 1, 5000);
        check("a.bn_line1", 64'(bn_a), 64'(1));
        count_while(1'b1, 0, n);
        check("a.hs_lead_clks", 64'(n), 64'(1312));
        count_while(1'b0, 0, lo);
        check("a.hs_low_clks", 64'(lo), 64'(192));
        count_while(1'b1, 0, hi);
        check("a.line_clks", 64'(lo + hi), 64'(1600));

        // colour bars on line 3
        wait_pix(0, 0, 3, 5000);
        check("a.bar_x0", 64'({r_a, g_a, b_a}), 64'(24'hFFFFFF));
        wait_pix(0, 80, 3, 500);
        check("a.bar_x80", 64'({r_a, g_a, b_a}), 64'(24'hFFFF00));
        wait_pix(0, 639, 3, 2000);
        check("a.bar_x639", 64'({r_a, g_a, b_a}), 64'(24'h000000));
        wait_pix(0, 640, 3, 10);
        check("a.bar_x640_rgb", 64'({r_a, g_a, b_a}), 64'(0));
        check("a.bar_x640_bn", 64'(bn_a), 64'(0));
        mode_a = 2'd2;

        // mid-frame mode switch on C takes effect only at the next frame
        wait_pix(2, 0, 40, 25000);
        mode_c = 2'd2;
        wait_pix(2, 10, 50, 3000);
        check("c.latch_same_frame", 64'({r_c, g_c, b_c}), 64'(sc_c));
        wait_fs_c(15000);
        check("c.fs_rgb", 64'({r_c, g_c, b_c}), 64'(0));
        check("c.fs_x", 64'(x_c), 64'(0));
        check("c.fs_y", 64'(y_c), 64'(0));
        check("c.fs_bn", 64'(bn_c), 64'(1));
        wait_pix(2, 32, 0, 200);
        check("c.chk_32_0", 64'({r_c, g_c, b_c}), 64'(sc_c));
        wait_pix(2, 0, 32, 6000);
        check("c.chk_0_32", 64'({r_c, g_c, b_c}), 64'(sc_c));
        wait_pix(2, 32, 32, 200);
        check("c.chk_32_32", 64'({r_c, g_c, b_c}), 64'(0));
        mode_c = 2'd3;
        rand_c = 1'b1;

        // asynchronous reset in the middle of a line on B
        wait_pix(1, 5, -1, 200);
        #1 rst = 1'b1;
        #1;
        check("b.arst_hs", 64'(hs_b), 64'(0));
        check("b.arst_vs", 64'(vs_b), 64'(0));
        check("b.arst_bn", 64'(bn_b), 64'(0));
        check("b.arst_x", 64'(x_b), 64'(0));
        check("b.arst_rgb", 64'({r_b, g_b, b_b}), 64'(0));
        check("b.arst_ck", 64'(ck_b), 64'(0));
        check("a.arst_hs", 64'(hs_a), 64'(1));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!fs_b && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b.restart_clks", 64'(n), 64'(4));
        check("b.restart_x", 64'(x_b), 64'(0));
        check("b.restart_y", 64'(y_b), 64'(0));

        // small-config line and frame timing
        count_while(1'b0, 1, n);
        count_while(1'b1, 1, hi);
        check("b.hs_high_clks", 64'(hi), 64'(8));
        count_while(1'b0, 1, lo);
        check("b.line_clks", 64'(hi + lo), 64'(48));
        n = 0;
        while (!fs_b && n < 400) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fs_b && n < 400);
        check("b.frame_clks", 64'(n), 64'(336));

        repeat (13000) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
